// File: rtl/dec_seg_dwa.sv
// Segmented DAC decoder: offset add with saturate/wrap into row/column thermometers, plus DWA-rotated unary bands.
// Latency 2 cycles from in_vld to out_vld; no backpressure, accepts one sample every cycle.
module dec_seg_dwa #(
  parameter int MTRX_BITS = 8,
  parameter int OS_BITS   = 2,
  parameter int BAND_BITS = 4,
  parameter int BAND_CH   = 2
) (
  input  logic                         dec_clk,
  input  logic                         dec_rst,
  input  logic                         csr_dec_en,
  input  logic                         csr_sat_en,
  input  logic                         csr_dwa_en,
  input  logic                         csr_ovf_clr,
  input  logic                         in_vld,
  input  logic [MTRX_BITS-1:0]         s_mtrx,
  input  logic [OS_BITS-1:0]           os_bin,
  input  logic [BAND_CH*BAND_BITS-1:0] s_band,
  output logic [4*(2**(MTRX_BITS/2))-1:0] mtrx_thrm,
  output logic [BAND_CH*(2**BAND_BITS-1)-1:0] band_thrm,
  output logic                         out_vld,
  output logic                         ovf_sticky
);
  localparam int H = MTRX_BITS / 2;
  localparam int N = 2 ** H;
  localparam int M = 2 ** BAND_BITS - 1;
  localparam logic [BAND_BITS:0] M_W = (BAND_BITS+1)'(M);

  typedef logic [BAND_CH-1:0][BAND_BITS-1:0] band_vec_t;

  typedef struct packed {
    logic                 vld;
    logic                 dwa;
    logic [MTRX_BITS-1:0] code;
    band_vec_t            band;
    band_vec_t            ptr;
  } s1_t;

  s1_t                        s1;
  band_vec_t                  in_band;
  band_vec_t                  ptr;
  band_vec_t                  ptr_nxt;
  logic [BAND_CH-1:0][BAND_BITS:0] ptr_sum;
  logic [MTRX_BITS:0]         sum;
  logic                       sum_ovf;
  logic [MTRX_BITS-1:0]       code_nxt;
  logic [H-1:0]               row;
  logic [H-1:0]               col;
  logic [4*N-1:0]             mtrx_nxt;
  logic [BAND_CH*M-1:0]       band_nxt;
  logic [BAND_CH-1:0][M-1:0]  therm;
  logic [BAND_CH-1:0][2*M-1:0] rot_ext;

  assign in_band  = s_band;
  assign sum      = {1'b0, s_mtrx} + (MTRX_BITS+1)'(os_bin);
  assign sum_ovf  = sum[MTRX_BITS];
  assign code_nxt = (sum_ovf && csr_sat_en) ? '1 : sum[MTRX_BITS-1:0];
  assign row      = s1.code[MTRX_BITS-1:H];
  assign col      = s1.code[H-1:0];

  // Pointer advance wraps modulo M; p < M and b <= M so one subtraction suffices.
  always_comb begin
    ptr_sum = '0;
    ptr_nxt = '0;
    for (int c = 0; c < BAND_CH; c++) begin
      ptr_sum[c] = {1'b0, ptr[c]} + {1'b0, in_band[c]};
      if (ptr_sum[c] >= M_W)
        ptr_nxt[c] = BAND_BITS'(ptr_sum[c] - M_W);
      else
        ptr_nxt[c] = ptr_sum[c][BAND_BITS-1:0];
    end
  end

  always_comb begin
    mtrx_nxt = '0;
    for (int i = 0; i < N; i++) begin
      mtrx_nxt[3*N+i] = (i == int'(row));
      mtrx_nxt[2*N+i] = (i <  int'(row));
      mtrx_nxt[N+i]   = !(i < int'(col));
      mtrx_nxt[i]     = (i < int'(col));
    end
  end

  // Rotation folds the upper half of a double-width shift back onto the low half.
  always_comb begin
    therm    = '0;
    rot_ext  = '0;
    band_nxt = '0;
    for (int c = 0; c < BAND_CH; c++) begin
      for (int i = 0; i < M; i++)
        therm[c][i] = (i < int'(s1.band[c]));
      rot_ext[c] = {{M{1'b0}}, therm[c]} << s1.ptr[c];
      band_nxt[c*M +: M] = s1.dwa ? (rot_ext[c][M-1:0] | rot_ext[c][2*M-1:M]) : therm[c];
    end
  end

  always_ff @(posedge dec_clk or posedge dec_rst) begin
    if (dec_rst) begin
      s1        <= '0;
      ptr       <= '0;
      mtrx_thrm <= '0;
      band_thrm <= '0;
      out_vld   <= 1'b0;
    end else if (!csr_dec_en) begin
      s1        <= '0;
      ptr       <= '0;
      mtrx_thrm <= '0;
      band_thrm <= '0;
      out_vld   <= 1'b0;
    end else begin
      s1.vld  <= in_vld;
      out_vld <= s1.vld;
      if (in_vld) begin
        s1.dwa  <= csr_dwa_en;
        s1.code <= code_nxt;
        s1.band <= in_band;
        s1.ptr  <= ptr;
        if (csr_dwa_en)
          ptr <= ptr_nxt;
      end
      if (s1.vld) begin
        mtrx_thrm <= mtrx_nxt;
        band_thrm <= band_nxt;
      end
    end
  end

  // Sticky flag survives decoder disable; a same-cycle set beats the clear.
  always_ff @(posedge dec_clk or posedge dec_rst) begin
    if (dec_rst)
      ovf_sticky <= 1'b0;
    else if (csr_dec_en && in_vld && sum_ovf)
      ovf_sticky <= 1'b1;
    else if (csr_ovf_clr)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: doc/dec_seg_dwa.md
Name: dec_seg_dwa

Overview:
- Parametrised, pipelined successor to the segmented DAC decoder.
- Main matrix path: adds a binary offset to the matrix code, then saturates or wraps the sum per CSR setting. The result is decoded into row/column thermometer control words.
- Band path: each of BAND_CH unary bands is decoded with optional data-weighted-averaging (DWA) rotation for element mismatch shaping.
- Sits between the digital modulator output and the DAC cell array. Adds valid tracking and a sticky overflow flag.

Parameters:
MTRX_BITS, 8, matrix code width; must be even. N = 2^(MTRX_BITS/2) rows and columns (16 at default).
OS_BITS, 2, offset code width; must be less than MTRX_BITS.
BAND_BITS, 4, per-band code width. M = 2^BAND_BITS-1 elements per band (15 at default).
BAND_CH, 2, number of band channels.

Ports:
dec_clk  in  1  decoder clock; all flops rise-edge.
dec_rst  in  1  asynchronous active-high reset.
csr_dec_en  in  1  decoder enable. Low forces outputs and pointers to 0 synchronously.
csr_sat_en  in  1  1 = saturate the matrix sum at max; 0 = wrap modulo 2^MTRX_BITS.
csr_dwa_en  in  1  1 = DWA rotation on band outputs; 0 = plain thermometer.
csr_ovf_clr  in  1  single-cycle pulse; clears ovf_sticky.
in_vld  in  1  input sample valid.
s_mtrx  in  MTRX_BITS  matrix code.
os_bin  in  OS_BITS  unsigned offset.
s_band  in  BAND_CH*BAND_BITS  band codes; channel c occupies [c*BAND_BITS +: BAND_BITS].
mtrx_thrm  out  4*N  {row_n, row_p, col_off, col_on}; col_on in the LSBs.
band_thrm  out  BAND_CH*M  channel c occupies [c*M +: M].
out_vld  out  1  outputs updated this cycle.
ovf_sticky  out  1  a matrix sum exceeded 2^MTRX_BITS-1.

Behaviour:

Reset and enable:
- dec_rst: all outputs, pipeline registers and DWA pointers go to 0.
- csr_dec_en = 0 has the same effect as reset, but synchronously.
- Exception: ovf_sticky is cleared only by reset or csr_ovf_clr, not by csr_dec_en.

Pipeline:
- Total latency is 2 cycles: in_vld at cycle T gives out_vld = 1 at T+2.
- Stage 1 (captured when in_vld = 1):
  - Compute sum = s_mtrx + os_bin in MTRX_BITS+1 bits.
  - If sum > 2^MTRX_BITS-1: with csr_sat_en = 1, register max (all ones); otherwise register sum mod 2^MTRX_BITS.
  - Register each band code and that channel's current pointer.
- Stage 2: decode the stage-1 registers into the output registers.
- Cycles with in_vld = 0 leave the stage registers and outputs unchanged.
- out_vld is a pulse that tracks the in_vld pipeline.

Matrix decode (code v after saturate/wrap):
- r = v[MTRX_BITS-1 : MTRX_BITS/2], k = v[MTRX_BITS/2-1 : 0].
- row_p[i] = (i < r).
- row_n[i] = (i == r), so row_n is one-hot.
- col_on[j] = (j < k).
- col_off = ~col_on.

Band decode, per channel (code b, pointer p, 0 <= p < M):
- DWA on: bits p, p+1, ..., p+b-1 (mod M) are set; all others are clear.
  - b = 0 gives all zeros.
  - b = M gives all ones.
- DWA off: bits 0 .. b-1 are set; p is ignored.

DWA pointer update:
- Occurs at stage-1 capture only, when in_vld = 1 and csr_dwa_en = 1.
- p <= (p + b) mod M.
- The sample uses the pre-update pointer.
- csr_dwa_en = 0 holds p at its current value, so toggling it does not reset the pointer.

Overflow flag:
- ovf_sticky sets on any stage-1 capture where sum > 2^MTRX_BITS-1, in both saturate and wrap modes.
- It clears on csr_ovf_clr.
- If set and clear occur in the same cycle, set wins.

Mid-stream events:
- csr_dec_en deasserted mid-pipeline discards in-flight samples; out_vld stays 0.
- After re-enable, the first output appears 2 cycles after the next in_vld.
- Back-to-back in_vld gives one output per cycle.

Test Plan:
1. Matrix basic: s_mtrx = 0x25, os_bin = 2, in_vld pulse → two cycles later, out_vld = 1 and mtrx_thrm = 0x0004_0003_FF80_007F.
2. Saturation: s_mtrx = 0xFF, os_bin = 3.
   - csr_sat_en = 1 → mtrx_thrm = 0x8000_7FFF_8000_7FFF and ovf_sticky = 1.
   - Repeat with csr_sat_en = 0 → mtrx_thrm = 0x0001_0000_FFFC_0003.
   - Pulse csr_ovf_clr → ovf_sticky = 0.
   - Pulse csr_ovf_clr in the same cycle as an overflowing capture → ovf_sticky stays 1.
3. DWA rotation, ch0, csr_dwa_en = 1: codes 5, 5, 7 back-to-back.
   - ch0 outputs: 0x001F, 0x03E0, 0x7C03.
   - Final pointer = 2.
   - A following code of 15 → 0x7FFF with pointer unchanged; a code of 0 → 0x0000.
4. DWA off: ch1 code 9 with pointer nonzero → band_thrm[29:15] = 0x01FF. Re-enabling csr_dwa_en resumes from the held pointer.
5. Reset and enable: assert dec_rst asynchronously between clock edges → all outputs 0 immediately.
   - Deassert csr_dec_en with a sample in flight → no out_vld, outputs 0, pointers 0.
   - ovf_sticky is retained until dec_rst.
6. Throughput: 8 consecutive in_vld samples with random codes → 8 consecutive out_vld cycles. Outputs must match a reference model at latency 2, with in_vld gaps holding the last outputs.
